// File: rtl/delay_meter_pkg.sv
// Shared types and defaults for the delay meter: FSM state encoding and
// default counter width / timeout.
package delay_meter_pkg;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 1000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_COUNT  = COUNT;
  localparam logic [1:0] ST_REPORT = REPORT;

endpackage

// File: rtl/delay_meter_if.sv
// Timer handshake and result bus of the delay meter; slave is the meter side,
// master is the timer/consumer side.
interface delay_meter_if
  import delay_meter_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
);
  logic             start;
  logic             done;
  logic             meas_ready;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_cycles;
  logic             meas_timeout;
  logic             busy;
  logic             overrun;

  modport slave (
    input  start, done, meas_ready,
    output meas_valid, meas_cycles, meas_timeout, busy, overrun
  );

  modport master (
    output start, done, meas_ready,
    input  meas_valid, meas_cycles, meas_timeout, busy, overrun
  );
endinterface

// File: rtl/delay_meter_edge_detect.sv
// Rising-edge detector; the first edge after reset only loads the history
// register, so a level already high at release is not taken as an edge.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic rise
);
  logic in_q;
  logic armed_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q    <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      in_q    <= in;
      armed_q <= 1'b1;
    end
  end

  assign rise = in & ~in_q & armed_q;
endmodule

// File: rtl/delay_meter.sv
// Measures clk cycles from a start rising edge to a done sample, with a
// timeout, and presents the result on a valid/ready handshake.
module delay_meter
  import delay_meter_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst_n,
  delay_meter_if.slave  bus
);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic [1:0]       state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] cycles_q,  cycles_d;
  logic             tmo_q,     tmo_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             start_rise;

  edge_detect u_start_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (bus.start),
    .rise  (start_rise)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    tmo_d    = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_COUNT;
          cnt_d   = '0;
        end
      end
      ST_COUNT: begin
        // done takes priority over a coincident timeout
        if (bus.done) begin
          cycles_d = cnt_inc;
          tmo_d    = 1'b0;
          state_d  = ST_REPORT;
        end else if (cnt_inc == TIMEOUT_C) begin
          cycles_d = TIMEOUT_C;
          tmo_d    = 1'b1;
          state_d  = ST_REPORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_REPORT: begin
        if (bus.meas_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    overrun_d = start_rise && (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cycles_q  <= '0;
      tmo_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
      tmo_q     <= tmo_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.meas_valid   = (state_q == ST_REPORT);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.meas_cycles  = cycles_q;
  assign bus.meas_timeout = tmo_q;
  assign bus.overrun      = overrun_q;
endmodule

// File: tb/tb_delay_meter.sv
// Directed bench for delay_meter: default-timeout instance plus a TIMEOUT=8
// instance, each step checked against hand-computed values.
module tb_delay_meter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  delay_meter_if #(.CNT_W(16)) bus  ();
  delay_meter_if #(.CNT_W(16)) bus8 ();

  delay_meter #(.CNT_W(16), .TIMEOUT(1000)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  delay_meter #(.CNT_W(16), .TIMEOUT(8)) u_t8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_cnt;
    int valid_cnt;
    logic [15:0] cyc_seen;
    logic        tmo_seen;

    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start  = 1'b0; bus.done  = 1'b0; bus.meas_ready  = 1'b1;
    bus8.start = 1'b0; bus8.done = 1'b0; bus8.meas_ready = 1'b1;

    // reset state, then basic 10 ns clock scenario (start at 10 ns, done at 60 ns)
    #2;
    check("rst_valid",   32'(bus.meas_valid),   0);
    check("rst_busy",    32'(bus.busy),         0);
    check("rst_overrun", 32'(bus.overrun),      0);
    check("rst_cycles",  32'(bus.meas_cycles),  0);
    check("rst_timeout", 32'(bus.meas_timeout), 0);
    #1 rst_n = 1'b1;
    #7 bus.start = 1'b1;
    #6;
    check("basic_busy",  32'(bus.busy),       1);
    check("basic_nval",  32'(bus.meas_valid), 0);
    #44 bus.done = 1'b1;
    #6;
    check("basic_valid",   32'(bus.meas_valid),   1);
    check("basic_cycles",  32'(bus.meas_cycles),  5);
    check("basic_timeout", 32'(bus.meas_timeout), 0);
    #4 bus.done = 1'b0;
    #6;
    check("basic_accept", 32'(bus.meas_valid),  0);
    check("basic_idle",   32'(bus.busy),        0);
    check("basic_hold",   32'(bus.meas_cycles), 5);
    bus.start = 1'b0;

    // done in IDLE ignored; start edge coincident with done; start drop in COUNT ignored
    tick();
    bus.done = 1'b1;
    tick();
    check("idle_done_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    check("idle_done_start", 32'(bus.busy),       1);
    check("idle_done_nval",  32'(bus.meas_valid), 0);
    bus.done = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("start_drop_busy", 32'(bus.busy), 1);
    bus.done = 1'b1;
    tick();
    check("idle_done_valid",  32'(bus.meas_valid),  1);
    check("idle_done_cycles", 32'(bus.meas_cycles), 4);
    bus.done = 1'b0;
    tick();
    check("idle_done_ret", 32'(bus.meas_valid), 0);

    // back-pressure in REPORT with done toggling and a dropped start edge
    bus.meas_ready = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    bus.done = 1'b1;
    tick();
    check("bp_valid", 32'(bus.meas_valid), 1);
    for (int i = 0; i < 5; i++) begin
      bus.done  = i[0];
      bus.start = (i == 2);
      tick();
      check("bp_hold_valid",   32'(bus.meas_valid),   1);
      check("bp_hold_cycles",  32'(bus.meas_cycles),  2);
      check("bp_hold_timeout", 32'(bus.meas_timeout), 0);
      check("bp_overrun",      32'(bus.overrun),      (i == 2) ? 1 : 0);
    end
    bus.done = 1'b0;
    bus.start = 1'b0;
    bus.meas_ready = 1'b1;
    tick();
    check("bp_accept", 32'(bus.meas_valid), 0);
    check("bp_idle",   32'(bus.busy),       0);
    tick();
    tick();
    check("bp_no_restart", 32'(bus.busy), 0);

    // reset mid-COUNT, released with start held high
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check("mid_busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(bus.busy),        0);
    check("mid_rst_valid",  32'(bus.meas_valid),  0);
    check("mid_rst_cycles", 32'(bus.meas_cycles), 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    check("rel_high_busy",  32'(bus.busy),       0);
    check("rel_high_valid", 32'(bus.meas_valid), 0);
    bus.start = 1'b0;
    tick();
    check("rel_low_busy", 32'(bus.busy), 0);
    bus.start = 1'b1;
    tick();
    check("rel_rise_busy", 32'(bus.busy), 1);
    bus.done = 1'b1;
    tick();
    check("min_cycles", 32'(bus.meas_cycles), 1);
    check("min_valid",  32'(bus.meas_valid),  1);
    bus.done = 1'b0;
    bus.start = 1'b0;
    tick();

    // TIMEOUT=8 instance: timeout with no done
    busy_cnt  = 0;
    valid_cnt = 0;
    cyc_seen  = '0;
    tmo_seen  = 1'b0;
    bus8.start = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus8.busy) busy_cnt++;
      if (bus8.meas_valid) begin
        valid_cnt++;
        cyc_seen = bus8.meas_cycles;
        tmo_seen = bus8.meas_timeout;
      end
    end
    check("tmo_busy_cycles", 32'(busy_cnt),  9);
    check("tmo_valid_count", 32'(valid_cnt), 1);
    check("tmo_cycles",      32'(cyc_seen),  8);
    check("tmo_flag",        32'(tmo_seen),  1);

    // TIMEOUT=8 instance: done on the 8th count cycle wins over timeout
    bus8.start = 1'b0;
    tick();
    bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("dw_pre_valid", 32'(bus8.meas_valid), 0);
    bus8.done = 1'b1;
    tick();
    check("dw_valid",   32'(bus8.meas_valid),   1);
    check("dw_cycles",  32'(bus8.meas_cycles),  8);
    check("dw_timeout", 32'(bus8.meas_timeout), 0);
    bus8.done = 1'b0;
    tick();
    check("dw_accept", 32'(bus8.meas_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
